// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmit path.
package uart_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XMIT = 1'b1
  } state_t;

  // Start + up to one parity + up to two stop bits on top of the data bits.
  localparam int unsigned FRAME_EXTRA = 4;
  localparam int unsigned PAR_MAX_W   = 9;

  function automatic int unsigned frame_w(input int unsigned data_bits);
    return data_bits + FRAME_EXTRA;
  endfunction

  function automatic logic parity(input logic [PAR_MAX_W-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_tx_q.sv
// Transmit queue storage: synchronous write, combinational read, no reset.
module uart_tx_q #(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 128
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_BITS-1:0]     wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_BITS-1:0]     rdata
);

  logic [DATA_BITS-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter with per-frame parity/stop configuration,
// flush, overflow detection and gap-free back-to-back frames.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned DEPTH     = 128,
  parameter int unsigned BAUD_W    = 13
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   trmt,
  input  logic [DATA_BITS-1:0]   tx_data,
  input  logic                   flush,
  input  logic [BAUD_W-1:0]      baud_reload,
  input  logic                   par_en,
  input  logic                   par_odd,
  input  logic                   stop2,
  output logic                   TX,
  output logic                   busy,
  output logic                   tx_done,
  output logic                   queue_full,
  output logic                   queue_empty,
  output logic [$clog2(DEPTH):0] entries_left,
  output logic                   overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned FW = frame_w(DATA_BITS);
  localparam int unsigned CW = $clog2(FW + 1);

  state_t              state_q, state_d;
  logic                load;
  logic                wr_en;
  logic                bit_end;
  logic                last_clk;
  logic [PW-1:0]       wrt_ptr, rd_ptr, occupancy;
  logic [DATA_BITS-1:0] rdata;
  logic [FW-1:0]       shift_q, frame;
  logic [CW-1:0]       bit_cnt, bit_total, bit_total_new;
  logic [BAUD_W-1:0]   baud_cnt;

  // Queue status straight from the registered pointers.
  assign occupancy    = wrt_ptr - rd_ptr;
  assign queue_full   = (occupancy == PW'(DEPTH));
  assign queue_empty  = (wrt_ptr == rd_ptr);
  assign entries_left = PW'(DEPTH) - occupancy;
  assign wr_en        = trmt & ~queue_full & ~flush;

  assign bit_end  = (baud_cnt == '0);
  assign last_clk = (state_q == XMIT) && bit_end && (bit_cnt == bit_total - CW'(1));

  uart_tx_q #(
    .DATA_BITS(DATA_BITS),
    .DEPTH    (DEPTH)
  ) u_q (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wrt_ptr[AW-1:0]),
    .wdata(tx_data),
    .raddr(rd_ptr[AW-1:0]),
    .rdata(rdata)
  );

  // Frame image for the head-of-queue word using the live configuration.
  always_comb begin
    frame                = '1;
    frame[0]             = 1'b0;
    frame[DATA_BITS:1]   = rdata;
    if (par_en) frame[DATA_BITS+1] = parity(PAR_MAX_W'(rdata), par_odd);
    bit_total_new = CW'(DATA_BITS + 2) + CW'(par_en) + CW'(stop2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (~queue_empty & ~flush) begin
          load    = 1'b1;
          state_d = XMIT;
        end
      end
      XMIT: begin
        if (last_clk) begin
          if (~queue_empty & ~flush) load = 1'b1;
          else                       state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Flush discards everything queued; a same-cycle write is already blocked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrt_ptr <= '0;
      rd_ptr  <= '0;
    end else begin
      if (wr_en) wrt_ptr <= wrt_ptr + PW'(1);
      if (flush)     rd_ptr <= wrt_ptr;
      else if (load) rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q   <= '1;
      bit_cnt   <= '0;
      bit_total <= '0;
      baud_cnt  <= '0;
    end else if (load) begin
      shift_q   <= frame;
      bit_cnt   <= '0;
      bit_total <= bit_total_new;
      baud_cnt  <= baud_reload;
    end else if (state_q == XMIT) begin
      if (bit_end) begin
        shift_q  <= {1'b1, shift_q[FW-1:1]};
        baud_cnt <= baud_reload;
        bit_cnt  <= bit_cnt + CW'(1);
      end else begin
        baud_cnt <= baud_cnt - BAUD_W'(1);
      end
    end
  end

  // tx_done is set one clock early so it coincides with the last stop-bit clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_done  <= 1'b0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      tx_done  <= (state_q == XMIT) && (bit_cnt == bit_total - CW'(1)) &&
                  (baud_cnt == BAUD_W'(1));
      overflow <= trmt & queue_full;
      busy     <= (state_d == XMIT);
    end
  end

  assign TX = shift_q[0];

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: expected frames queued at enqueue time,
// a line monitor decodes TX and checks bit values, bit timing and tx_done.
module tb_uart_tx_cfg;

  typedef struct {
    logic [15:0] bits;
    int          len;
    int          baud;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        trmt;
  logic [7:0]  tx_data;
  logic        flush;
  logic [12:0] baud_reload;
  logic        par_en, par_odd, stop2;
  logic        TX, busy, tx_done, queue_full, queue_empty, overflow;
  logic [2:0]  entries_left;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int frames_done = 0;
  int mon_bit = -1;
  int idle_done_err = 0;
  int last_trmt_cyc = 0;
  exp_t exp_q[$];
  int start_q[$];
  int end_q[$];

  uart_tx_cfg #(.DATA_BITS(8), .DEPTH(4), .BAUD_W(13)) dut (
    .clk(clk), .rst_n(rst_n), .trmt(trmt), .tx_data(tx_data), .flush(flush),
    .baud_reload(baud_reload), .par_en(par_en), .par_odd(par_odd), .stop2(stop2),
    .TX(TX), .busy(busy), .tx_done(tx_done), .queue_full(queue_full),
    .queue_empty(queue_empty), .entries_left(entries_left), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference frame: start, data LSB first, optional parity, stop bit(s).
  function automatic exp_t model(input logic [7:0] d, input bit pe, input bit po,
                                 input bit s2, input int baud);
    exp_t e;
    int n;
    e.bits = '0;
    n = 1;
    for (int i = 0; i < 8; i++) begin
      e.bits[n] = d[i];
      n++;
    end
    if (pe) begin
      e.bits[n] = ((($countones(d) % 2) == 1) ? 1'b1 : 1'b0) ^ po;
      n++;
    end
    e.bits[n] = 1'b1;
    n++;
    if (s2) begin
      e.bits[n] = 1'b1;
      n++;
    end
    e.len  = n;
    e.baud = baud;
    return e;
  endfunction

  task automatic send(input logic [7:0] d, input bit accept);
    trmt    = 1'b1;
    tx_data = d;
    if (accept) exp_q.push_back(model(d, par_en, par_odd, stop2, int'(baud_reload)));
    last_trmt_cyc = cyc;
    @(posedge clk);
    #1;
    trmt = 1'b0;
  endtask

  task automatic wait_frames(input int target, input int budget);
    int k;
    k = 0;
    while (frames_done < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("wait_frames", 32'(frames_done >= target), 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Line monitor: pops one expected frame per observed start bit.
  initial begin : monitor
    exp_t it;
    logic [15:0] got;
    bit unstable, done_bad, aborted;
    int start;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (TX !== 1'b0) begin
        if (tx_done === 1'b1) idle_done_err++;
        continue;
      end
      start = cyc;
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", 32'd1, 32'd0);
        continue;
      end
      it = exp_q.pop_front();
      got = '0;
      unstable = 0;
      done_bad = 0;
      aborted = 0;
      for (int b = 0; b < it.len && !aborted; b++) begin
        mon_bit = b;
        for (int c = 0; c <= it.baud; c++) begin
          if (b != 0 || c != 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1;
            break;
          end
          if (c == 0) got[b] = TX;
          else if (TX !== got[b]) unstable = 1;
          if (tx_done !== ((b == it.len - 1 && c == it.baud) ? 1'b1 : 1'b0)) done_bad = 1;
        end
      end
      mon_bit = -1;
      if (aborted) begin
        exp_q.delete();
        continue;
      end
      chk("frame_bits", 32'(got), 32'(it.bits));
      chk("bit_hold", 32'(unstable), 32'd0);
      chk("tx_done_pos", 32'(done_bad), 32'd0);
      start_q.push_back(start);
      end_q.push_back(cyc);
      frames_done++;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n0, k, ov_cnt, n;
    rst_n = 1'b0; trmt = 1'b0; tx_data = '0; flush = 1'b0;
    baud_reload = 13'd3; par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;
    cycles(3);
    chk("rst_tx", 32'(TX), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_full", 32'(queue_full), 32'd0);
    chk("rst_empty", 32'(queue_empty), 32'd1);
    chk("rst_entries", 32'(entries_left), 32'd4);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles(2);

    // Single 8N1 frame: latency, length, busy drop.
    send(8'hA5, 1);
    wait_frames(1, 200);
    chk("latency", 32'(start_q[0]), 32'(last_trmt_cyc + 2));
    chk("len_8n1", 32'(end_q[0] - start_q[0] + 1), 32'd40);
    while (cyc <= end_q[end_q.size()-1]) @(negedge clk);
    chk("busy_after_done", 32'(busy), 32'd0);

    // Odd parity, two stop bits.
    par_en = 1'b1; par_odd = 1'b1; stop2 = 1'b1;
    send(8'h07, 1);
    wait_frames(2, 200);
    chk("len_8o2", 32'(end_q[1] - start_q[1] + 1), 32'd48);
    par_en = 1'b0; par_odd = 1'b0; stop2 = 1'b0;
    cycles(2);

    // Fill and overflow while the transmitter is busy.
    n0 = frames_done;
    send(8'h3C, 1);
    cycles(3);
    for (int i = 0; i < 4; i++) send(8'(8'h40 + i), 1);
    chk("full_after_4", 32'(queue_full), 32'd1);
    chk("entries_full", 32'(entries_left), 32'd0);
    send(8'hEE, 0);
    ov_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (overflow === 1'b1) ov_cnt++;
      cycles(1);
    end
    chk("overflow_pulses", 32'(ov_cnt), 32'd1);
    wait_frames(n0 + 5, 2000);
    chk("empty_after_fill", 32'(queue_empty), 32'd1);
    chk("entries_after_fill", 32'(entries_left), 32'd4);
    cycles(2);

    // Back-to-back frames with no idle clock.
    n0 = frames_done;
    send(8'h11, 1);
    send(8'h22, 1);
    send(8'h33, 1);
    wait_frames(n0 + 3, 1000);
    chk("b2b_gap1", 32'(start_q[n0+1]), 32'(end_q[n0] + 1));
    chk("b2b_gap2", 32'(start_q[n0+2]), 32'(end_q[n0+1] + 1));
    chk("b2b_empty", 32'(queue_empty), 32'd1);
    chk("b2b_entries", 32'(entries_left), 32'd4);
    cycles(2);

    // Flush during the first frame drops the two queued words.
    n0 = frames_done;
    send(8'h5A, 1);
    send(8'h66, 0);
    send(8'h77, 0);
    cycles(5);
    flush = 1'b1;
    cycles(1);
    flush = 1'b0;
    chk("flush_empty", 32'(queue_empty), 32'd1);
    chk("flush_entries", 32'(entries_left), 32'd4);
    chk("flush_busy", 32'(busy), 32'd1);
    wait_frames(n0 + 1, 500);
    repeat (60) @(negedge clk);
    chk("flush_frames", 32'(frames_done), 32'(n0 + 1));
    chk("flush_idle", 32'(busy), 32'd0);
    cycles(1);

    // Asynchronous reset in the middle of data bit 3.
    send(8'hC3, 1);
    k = 0;
    while (mon_bit != 4 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("reach_bit3", 32'(mon_bit), 32'd4);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstmid_tx", 32'(TX), 32'd1);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_entries", 32'(entries_left), 32'd4);
    chk("rstmid_empty", 32'(queue_empty), 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cycles(2);
    n0 = frames_done;
    send(8'h96, 1);
    wait_frames(n0 + 1, 200);
    cycles(2);

    // Random bursts; frame config scrambled after the last load.
    for (int r = 0; r < 6; r++) begin
      baud_reload = 13'($urandom_range(1, 4));
      par_en  = 1'($urandom);
      par_odd = 1'($urandom);
      stop2   = 1'($urandom);
      n  = int'($urandom_range(1, 3));
      n0 = frames_done;
      for (int i = 0; i < n; i++) send(8'($urandom), 1);
      k = 0;
      while (!(busy === 1'b1 && queue_empty === 1'b1) && k < 500) begin
        @(negedge clk);
        k++;
      end
      par_en  = 1'($urandom);
      par_odd = 1'($urandom);
      stop2   = 1'($urandom);
      wait_frames(n0 + n, 3000);
      cycles(2);
    end

    chk("idle_tx_done", 32'(idle_done_err), 32'd0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
